// File: rtl/data_cache_pkg.sv
// Shared definitions for the direct-mapped data cache: default geometry,
// FSM state encodings and a byte-lane helper.
package data_cache_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_INDEX_W = 3;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] FETCH     = 2'd2;

  function automatic logic [7:0] selectByte(input logic [31:0] block, input logic [1:0] offset);
    return block[{offset, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/data_cache_array.sv
// Line storage for the data cache: valid/dirty bits (async cleared), tags and
// 32-bit blocks, with a byte-write port, a block-fill port and combinational lookup.
import data_cache_pkg::*;

module data_cache_array #(
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int TAG_W   = DEF_ADDR_W - DEF_INDEX_W - 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INDEX_W-1:0] index_i,
  input  logic [TAG_W-1:0]   tag_i,
  input  logic [1:0]         offset_i,
  input  logic               byteWrite_i,
  input  logic [7:0]         byteData_i,
  input  logic               fill_i,
  input  logic [31:0]        fillData_i,
  output logic               hit_o,
  output logic [7:0]         readData_o,
  output logic               victimValid_o,
  output logic               victimDirty_o,
  output logic [TAG_W-1:0]   victimTag_o,
  output logic [31:0]        victimData_o
);

  localparam int SETS = 1 << INDEX_W;

  logic [SETS-1:0]  valid_q;
  logic [SETS-1:0]  dirty_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS];

  // Only the status bits are reset; tags and data are don't-care until valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_i) begin
      valid_q[index_i] <= 1'b1;
      dirty_q[index_i] <= 1'b0;
    end else if (byteWrite_i) begin
      dirty_q[index_i] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (fill_i) begin
      tag_q[index_i]  <= tag_i;
      data_q[index_i] <= fillData_i;
    end else if (byteWrite_i) begin
      data_q[index_i][{offset_i, 3'b000} +: 8] <= byteData_i;
    end
  end

  assign victimValid_o = valid_q[index_i];
  assign victimDirty_o = dirty_q[index_i];
  assign victimTag_o   = tag_q[index_i];
  assign victimData_o  = data_q[index_i];
  assign hit_o         = valid_q[index_i] && (tag_q[index_i] == tag_i);
  assign readData_o    = valid_q[index_i] ? selectByte(data_q[index_i], offset_i) : 8'h00;

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate data cache: byte-wide CPU side,
// 32-bit block memory side, stalling the CPU while it writes back and refills.
import data_cache_pkg::*;

module data_cache #(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INDEX_W = DEF_INDEX_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [7:0]        writedata,
  output logic [7:0]        readdata,
  output logic              busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-3:0] mem_address,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_busywait
);

  localparam int TAG_W = ADDR_W - INDEX_W - 2;

  logic [1:0]         state_q, state_d;
  logic [TAG_W-1:0]   cpuTag;
  logic [INDEX_W-1:0] cpuIndex;
  logic [1:0]         cpuOffset;
  logic               request;
  logic               hit;
  logic               byteWrite;
  logic               fill;
  logic               victimValid;
  logic               victimDirty;
  logic [TAG_W-1:0]   victimTag;
  logic [31:0]        victimData;

  assign cpuTag    = address[ADDR_W-1 -: TAG_W];
  assign cpuIndex  = address[INDEX_W+1:2];
  assign cpuOffset = address[1:0];

  // A simultaneous read and write is illegal and treated as no request at all.
  assign request   = read ^ write;
  assign byteWrite = (state_q == IDLE) && write && !read && hit;
  assign fill      = (state_q == FETCH) && !mem_busywait;
  assign busywait  = !reset && request && (!hit || (state_q != IDLE));

  data_cache_array #(
    .INDEX_W(INDEX_W),
    .TAG_W  (TAG_W)
  ) u_array (
    .clock        (clock),
    .reset        (reset),
    .index_i      (cpuIndex),
    .tag_i        (cpuTag),
    .offset_i     (cpuOffset),
    .byteWrite_i  (byteWrite),
    .byteData_i   (writedata),
    .fill_i       (fill),
    .fillData_i   (mem_readdata),
    .hit_o        (hit),
    .readData_o   (readdata),
    .victimValid_o(victimValid),
    .victimDirty_o(victimDirty),
    .victimTag_o  (victimTag),
    .victimData_o (victimData)
  );

  // Memory states are entered on one edge and can only leave on a later one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (request && !hit) state_d = (victimValid && victimDirty) ? WRITEBACK : FETCH;
      WRITEBACK: if (!mem_busywait) state_d = FETCH;
      FETCH:     if (!mem_busywait) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign mem_write     = (state_q == WRITEBACK);
  assign mem_read      = (state_q == FETCH);
  assign mem_address   = (state_q == WRITEBACK) ? {victimTag, cpuIndex} : {cpuTag, cpuIndex};
  assign mem_writedata = victimData;

  addrStable: assert property (@(posedge clock) disable iff (reset)
    busywait |=> ($stable(address) && $stable(writedata)));

endmodule
